// File: rtl/lbist_pkg.sv
// Shared types and helpers for the LBIST controller: FSM state encoding and
// word slicing out of the packed seed / golden-signature parameters.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lbist_state_e;

    localparam int unsigned SLICE_VEC_BITS  = 4096;
    localparam int unsigned SLICE_WORD_BITS = 64;

    // Returns word idx of a packed vector of width-bit words (width <= 64).
    function automatic logic [SLICE_WORD_BITS-1:0] slice_word(
        input logic [SLICE_VEC_BITS-1:0] vec,
        input int unsigned               idx,
        input int unsigned               width
    );
        logic [SLICE_VEC_BITS-1:0]  shifted;
        logic [SLICE_WORD_BITS-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = (width >= SLICE_WORD_BITS) ? '1 : ~({SLICE_WORD_BITS{1'b1}} << width);
        return shifted[SLICE_WORD_BITS-1:0] & mask;
    endfunction

endpackage

// File: rtl/lbist_ctrl.sv
// LBIST run sequencer: feeds each seed to the LFSR, asks the MISR for a hash,
// compares the returned signature with its golden value and reports a pass vector.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned NUM_SEEDS           = 8,
    parameter int unsigned SEED_BITS           = 32,
    parameter int unsigned SIGNATURE_BITS      = 32,
    parameter int unsigned MAX_OUTPUTS_TO_HASH = 32,
    parameter int unsigned LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter logic [NUM_SEEDS*SEED_BITS-1:0]      LBIST_SEEDS          = '0,
    parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] LBIST_EXP_SIGNATURES = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lbist_req_val,
    output logic                      lbist_req_rdy,
    output logic                      lbist_resp_val,
    output logic [NUM_SEEDS-1:0]      lbist_resp_msg,
    input  logic                      lbist_resp_rdy,
    output logic                      lfsr_resp_val,
    output logic [SEED_BITS-1:0]      lfsr_resp_msg,
    input  logic                      lfsr_resp_rdy,
    output logic                      misr_req_val,
    output logic [LBIST_MSG_BITS:0]   misr_req_msg,
    input  logic                      misr_req_rdy,
    input  logic                      misr_resp_val,
    input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
    output logic                      misr_resp_rdy
);

    localparam int unsigned IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
    localparam logic [IDX_BITS-1:0]     LAST_IDX   = IDX_BITS'(NUM_SEEDS - 1);
    localparam logic [LBIST_MSG_BITS:0] HASH_COUNT = (LBIST_MSG_BITS + 1)'(MAX_OUTPUTS_TO_HASH);

    lbist_state_e           state_q, state_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [NUM_SEEDS-1:0]   result_q, result_d;
    logic                   lfsr_sent_q, lfsr_sent_d;
    logic                   misr_sent_q, misr_sent_d;

    logic [SEED_BITS-1:0]      cur_seed;
    logic [SIGNATURE_BITS-1:0] cur_exp;
    logic                      lfsr_fire;
    logic                      misr_req_fire;
    logic                      sig_match;

    assign cur_seed = SEED_BITS'(slice_word(SLICE_VEC_BITS'(LBIST_SEEDS),
                                            32'(idx_q), SEED_BITS));
    assign cur_exp  = SIGNATURE_BITS'(slice_word(SLICE_VEC_BITS'(LBIST_EXP_SIGNATURES),
                                                 32'(idx_q), SIGNATURE_BITS));

    assign lfsr_fire     = lfsr_resp_val && lfsr_resp_rdy;
    assign misr_req_fire = misr_req_val && misr_req_rdy;
    assign sig_match     = (misr_resp_msg == cur_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            result_q    <= '0;
            lfsr_sent_q <= 1'b0;
            misr_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            lfsr_sent_q <= lfsr_sent_d;
            misr_sent_q <= misr_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        result_d    = result_q;
        lfsr_sent_d = lfsr_sent_q;
        misr_sent_d = misr_sent_q;
        unique case (state_q)
            IDLE: begin
                if (lbist_req_val) begin
                    state_d     = SEED;
                    idx_d       = '0;
                    result_d    = '0;
                    lfsr_sent_d = 1'b0;
                    misr_sent_d = 1'b0;
                end
            end
            SEED: begin
                // The two transfers are independent; leave once both have fired.
                if (lfsr_fire)     lfsr_sent_d = 1'b1;
                if (misr_req_fire) misr_sent_d = 1'b1;
                if (lfsr_sent_d && misr_sent_d) state_d = WAIT;
            end
            WAIT: begin
                if (misr_resp_val) begin
                    result_d[idx_q] = sig_match;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_q + IDX_BITS'(1);
                        lfsr_sent_d = 1'b0;
                        misr_sent_d = 1'b0;
                        state_d     = SEED;
                    end
                end
            end
            DONE: begin
                if (lbist_resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lbist_req_rdy  = 1'b0;
        lbist_resp_val = 1'b0;
        lbist_resp_msg = '0;
        lfsr_resp_val  = 1'b0;
        lfsr_resp_msg  = cur_seed;
        misr_req_val   = 1'b0;
        misr_req_msg   = HASH_COUNT;
        misr_resp_rdy  = 1'b0;
        unique case (state_q)
            IDLE: lbist_req_rdy = 1'b1;
            SEED: begin
                lfsr_resp_val = !lfsr_sent_q;
                misr_req_val  = !misr_sent_q;
            end
            WAIT: misr_resp_rdy = 1'b1;
            DONE: begin
                lbist_resp_val = 1'b1;
                lbist_resp_msg = result_q;
            end
            default: lbist_req_rdy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lbist_ctrl.sv
// Randomized bench for lbist_ctrl: a transaction-level model tracks each run
// (seed order, hash requests, signatures consumed) and predicts the pass vector.
module tb_lbist_ctrl;

    localparam int unsigned NUM_SEEDS = 2;
    localparam int unsigned SEED_BITS = 32;
    localparam int unsigned SIG_BITS  = 32;
    localparam int unsigned MAX_OUT   = 32;
    localparam int unsigned MSG_BITS  = $clog2(MAX_OUT);
    localparam logic [63:0] SEEDS_PACKED = {32'h12345678, 32'hDEADBEEF};
    localparam logic [63:0] EXPS_PACKED  = {32'hBBBB0002, 32'hAAAA0001};

    logic                clk;
    logic                reset;
    logic                lbist_req_val;
    logic                lbist_req_rdy;
    logic                lbist_resp_val;
    logic [NUM_SEEDS-1:0] lbist_resp_msg;
    logic                lbist_resp_rdy;
    logic                lfsr_resp_val;
    logic [SEED_BITS-1:0] lfsr_resp_msg;
    logic                lfsr_resp_rdy;
    logic                misr_req_val;
    logic [MSG_BITS:0]   misr_req_msg;
    logic                misr_req_rdy;
    logic                misr_resp_val;
    logic [SIG_BITS-1:0] misr_resp_msg;
    logic                misr_resp_rdy;

    logic [31:0] seed_tab [NUM_SEEDS] = '{32'hDEADBEEF, 32'h12345678};
    logic [31:0] gold_tab [NUM_SEEDS] = '{32'hAAAA0001, 32'hBBBB0002};

    int num_checks = 0;
    int num_fails  = 0;
    int cyc        = 0;

    bit              run_active = 0;
    bit              fast_mode  = 0;
    bit              want_start = 0;
    bit              hold_resp  = 0;
    int              lfsr_cnt   = 0;
    int              mreq_cnt   = 0;
    int              sig_cnt    = 0;
    int              runs_done  = 0;
    int              start_edge = 0;
    logic [31:0]     run_sigs [NUM_SEEDS];
    logic [NUM_SEEDS-1:0] exp_result;

    bit              prev_lfsr_hold = 0;
    bit              prev_mreq_hold = 0;
    bit              prev_resp_hold = 0;
    bit              prev_resp_val  = 0;
    logic [31:0]     prev_lfsr_msg;
    logic [MSG_BITS:0] prev_mreq_msg;
    logic [NUM_SEEDS-1:0] prev_resp_msg;

    lbist_ctrl #(
        .NUM_SEEDS(NUM_SEEDS),
        .SEED_BITS(SEED_BITS),
        .SIGNATURE_BITS(SIG_BITS),
        .MAX_OUTPUTS_TO_HASH(MAX_OUT),
        .LBIST_MSG_BITS(MSG_BITS),
        .LBIST_SEEDS(SEEDS_PACKED),
        .LBIST_EXP_SIGNATURES(EXPS_PACKED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lbist_req_val(lbist_req_val),
        .lbist_req_rdy(lbist_req_rdy),
        .lbist_resp_val(lbist_resp_val),
        .lbist_resp_msg(lbist_resp_msg),
        .lbist_resp_rdy(lbist_resp_rdy),
        .lfsr_resp_val(lfsr_resp_val),
        .lfsr_resp_msg(lfsr_resp_msg),
        .lfsr_resp_rdy(lfsr_resp_rdy),
        .misr_req_val(misr_req_val),
        .misr_req_msg(misr_req_msg),
        .misr_req_rdy(misr_req_rdy),
        .misr_resp_val(misr_resp_val),
        .misr_resp_msg(misr_resp_msg),
        .misr_resp_rdy(misr_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Transaction observer: sampled mid-cycle, so inputs and Moore outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("req_rdy", 64'(lbist_req_rdy), 64'(!run_active));
            if (!run_active)
                checkOutput("idle_outputs",
                            64'({lfsr_resp_val, misr_req_val, lbist_resp_val, misr_resp_rdy}), 64'(0));
            if (prev_lfsr_hold)
                checkOutput("lfsr_hold", 64'({lfsr_resp_val, lfsr_resp_msg}), 64'({1'b1, prev_lfsr_msg}));
            if (prev_mreq_hold)
                checkOutput("misr_req_hold", 64'({misr_req_val, misr_req_msg}), 64'({1'b1, prev_mreq_msg}));
            if (prev_resp_hold)
                checkOutput("resp_hold", 64'({lbist_resp_val, lbist_resp_msg}), 64'({1'b1, prev_resp_msg}));
            if (run_active && fast_mode && lbist_resp_val && !prev_resp_val)
                checkOutput("latency", 64'(cyc - start_edge), 64'(2 * NUM_SEEDS));

            if (lfsr_resp_val && lfsr_resp_rdy) begin
                checkOutput("lfsr_order", 64'(lfsr_cnt), 64'(sig_cnt));
                if (lfsr_cnt < NUM_SEEDS)
                    checkOutput("lfsr_msg", 64'(lfsr_resp_msg), 64'(seed_tab[lfsr_cnt]));
                lfsr_cnt++;
            end
            if (misr_req_val && misr_req_rdy) begin
                checkOutput("misr_req_order", 64'(mreq_cnt), 64'(sig_cnt));
                checkOutput("misr_req_msg", 64'(misr_req_msg), 64'(MAX_OUT));
                mreq_cnt++;
            end
            if (misr_resp_val && misr_resp_rdy) begin
                checkOutput("sig_after_seed", 64'(lfsr_cnt), 64'(sig_cnt + 1));
                checkOutput("sig_after_req", 64'(mreq_cnt), 64'(sig_cnt + 1));
                sig_cnt++;
            end

            if (lbist_resp_val && lbist_resp_rdy) begin
                checkOutput("resp_msg", 64'(lbist_resp_msg), 64'(exp_result));
                checkOutput("resp_sig_count", 64'(sig_cnt), 64'(NUM_SEEDS));
                run_active = 0;
                runs_done++;
            end else if (lbist_req_val && lbist_req_rdy) begin
                run_active = 1;
                lfsr_cnt   = 0;
                mreq_cnt   = 0;
                sig_cnt    = 0;
                start_edge = cyc + 1;
            end

            prev_lfsr_hold = lfsr_resp_val && !lfsr_resp_rdy;
            prev_lfsr_msg  = lfsr_resp_msg;
            prev_mreq_hold = misr_req_val && !misr_req_rdy;
            prev_mreq_msg  = misr_req_msg;
            prev_resp_hold = lbist_resp_val && !lbist_resp_rdy;
            prev_resp_msg  = lbist_resp_msg;
            prev_resp_val  = lbist_resp_val;
        end
    end

    // One cycle of environment behaviour: LFSR, MISR and requester.
    task automatic driveCycle();
        lfsr_resp_rdy = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
        misr_req_rdy  = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (hold_resp) begin
            misr_resp_val = 1'b0;
            misr_resp_msg = $urandom;
        end else if (misr_resp_rdy && sig_cnt < NUM_SEEDS) begin
            misr_resp_val = fast_mode ? 1'b1 : 1'($urandom_range(0, 1));
            misr_resp_msg = run_sigs[sig_cnt];
        end else begin
            misr_resp_val = fast_mode ? 1'b1 : 1'($urandom_range(0, 1));
            misr_resp_msg = $urandom;
        end
        lbist_resp_rdy = fast_mode ? 1'b1 : ($urandom_range(0, 3) == 0);
        lbist_req_val  = run_active ? 1'($urandom_range(0, 1)) : want_start;
        if (run_active) want_start = 0;
    endtask

    task automatic applyStimulus(input bit fast, input logic [31:0] sig0, input logic [31:0] sig1);
        int start_runs;
        run_sigs[0] = sig0;
        run_sigs[1] = sig1;
        for (int i = 0; i < NUM_SEEDS; i++) exp_result[i] = (run_sigs[i] == gold_tab[i]);
        fast_mode  = fast;
        want_start = 1;
        start_runs = runs_done;
        for (int k = 0; k < 400 && runs_done == start_runs; k++) begin
            @(posedge clk);
            #1;
            driveCycle();
        end
        if (runs_done == start_runs)
            checkOutput("run_timeout", 64'(runs_done), 64'(start_runs + 1));
        want_start = 0;
    endtask

    task automatic resetMidRun();
        run_sigs[0] = gold_tab[0];
        run_sigs[1] = gold_tab[1];
        fast_mode  = 1;
        hold_resp  = 1;
        want_start = 1;
        for (int k = 0; k < 100 && !(run_active && lfsr_cnt == 2 && mreq_cnt == 2); k++) begin
            @(posedge clk);
            #1;
            driveCycle();
        end
        checkOutput("wait_before_reset", 64'(misr_resp_rdy), 64'(1));
        #1 reset = 1'b0;
        #1;
        checkOutput("async_rst_outputs",
                    64'({lfsr_resp_val, misr_req_val, lbist_resp_val, misr_resp_rdy}), 64'(0));
        checkOutput("async_rst_req_rdy", 64'(lbist_req_rdy), 64'(1));
        checkOutput("async_rst_resp_msg", 64'(lbist_resp_msg), 64'(0));
        run_active     = 0;
        hold_resp      = 0;
        want_start     = 0;
        prev_lfsr_hold = 0;
        prev_mreq_hold = 0;
        prev_resp_hold = 0;
        prev_resp_val  = 0;
        lbist_req_val  = 1'b0;
        misr_resp_val  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] s0, s1;
        int expected_runs;
        reset          = 1'b0;
        lbist_req_val  = 1'b0;
        lbist_resp_rdy = 1'b0;
        lfsr_resp_rdy  = 1'b0;
        misr_req_rdy   = 1'b0;
        misr_resp_val  = 1'b0;
        misr_resp_msg  = '0;
        #2;
        checkOutput("rst_req_rdy", 64'(lbist_req_rdy), 64'(1));
        checkOutput("rst_outputs",
                    64'({lfsr_resp_val, misr_req_val, lbist_resp_val, misr_resp_rdy}), 64'(0));
        checkOutput("rst_resp_msg", 64'(lbist_resp_msg), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] directed: all pass, then second signature wrong");
        applyStimulus(1, gold_tab[0], gold_tab[1]);
        applyStimulus(1, gold_tab[0], 32'hBBBB0003);
        expected_runs = 2;

        $display("[TB] directed: reset during final WAIT, then fresh run");
        resetMidRun();
        applyStimulus(1, gold_tab[0], gold_tab[1]);
        expected_runs++;

        $display("[TB] randomized runs with backpressure and spurious signatures");
        for (int r = 0; r < 30; r++) begin
            s0 = ($urandom_range(0, 1) != 0) ? gold_tab[0] : (gold_tab[0] ^ ($urandom | 32'h1));
            s1 = ($urandom_range(0, 1) != 0) ? gold_tab[1] : (gold_tab[1] ^ ($urandom | 32'h1));
            applyStimulus(0, s0, s1);
            expected_runs++;
        end
        repeat (3) @(posedge clk);
        checkOutput("runs_completed", 64'(runs_done), 64'(expected_runs));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/lbist_ctrl.md
Name: lbist_ctrl

Overview:
LBIST controller that sits directly upstream and downstream of the MISR. It sequences one LBIST run:
- For each of NUM_SEEDS seeds, it loads the seed into the LFSR pattern generator and tells the MISR how many CUT outputs to hash.
- It collects the MISR signature and compares it against a golden signature.
- At the end it reports a per-seed pass/fail vector to the top-level requester over a val/rdy interface.

Parameters:
NUM_SEEDS, 8, number of seeds (test sessions) per run.
SEED_BITS, 32, LFSR seed width.
SIGNATURE_BITS, 32, MISR signature width.
MAX_OUTPUTS_TO_HASH, 32, CUT outputs hashed per seed; sent to the MISR as its request message.
LBIST_MSG_BITS, $clog2(MAX_OUTPUTS_TO_HASH), MISR request message width is LBIST_MSG_BITS+1.
LBIST_SEEDS, '0, packed [NUM_SEEDS*SEED_BITS-1:0]; seed i is bits [i*SEED_BITS +: SEED_BITS].
LBIST_EXP_SIGNATURES, '0, packed [NUM_SEEDS*SIGNATURE_BITS-1:0]; golden signature i, same slicing.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
lbist_req_val  in  1  start request valid
lbist_req_rdy  out  1  controller ready to start
lbist_resp_val  out  1  result valid
lbist_resp_msg  out  NUM_SEEDS  bit i = 1 if seed i signature matched
lbist_resp_rdy  in  1  result consumed
lfsr_resp_val  out  1  seed valid to LFSR
lfsr_resp_msg  out  SEED_BITS  seed value
lfsr_resp_rdy  in  1  LFSR accepts seed
misr_req_val  out  1  hash-count request valid to MISR
misr_req_msg  out  LBIST_MSG_BITS+1  = MAX_OUTPUTS_TO_HASH
misr_req_rdy  in  1  MISR accepts request
misr_resp_val  in  1  signature valid from MISR
misr_resp_msg  in  SIGNATURE_BITS  signature
misr_resp_rdy  out  1  controller accepts signature

Behaviour:
- Handshake: a transfer fires when val && rdy are high at posedge clk.
- All outputs are Moore, decoded from registered state and flags; no combinational path from any input to any output.
- Reset (async assert, sync deassert externally guaranteed):
  - state=IDLE, idx=0, result=0, lfsr_sent=0, misr_sent=0.
  - Outputs: all *_val=0, misr_resp_rdy=0, lbist_req_rdy=1, lbist_resp_msg=0.
  - Reset asserted mid-run aborts immediately; no partial result is emitted.
- IDLE:
  - lbist_req_rdy=1; all other vals and rdys are 0.
  - On lbist_req fire: result<=0, idx<=0, both sent flags <=0, go to SEED.
- SEED:
  - lfsr_resp_val=!lfsr_sent, lfsr_resp_msg=seed[idx].
  - misr_req_val=!misr_sent, misr_req_msg=MAX_OUTPUTS_TO_HASH.
  - Each fire sets its sent flag.
  - When both transfers are done (same cycle or different cycles), go to WAIT.
  - A val, once raised, stays high with stable msg until its own fire; it is never dropped early.
  - misr_resp_rdy=0, so any misr_resp_val in this state is ignored.
- WAIT:
  - misr_resp_rdy=1.
  - On fire: result[idx] <= (misr_resp_msg == exp[idx]).
  - If idx==NUM_SEEDS-1, go to DONE; otherwise idx<=idx+1, clear both sent flags, go to SEED.
- DONE:
  - lbist_resp_val=1, lbist_resp_msg=result (held stable); lbist_req_rdy=0.
  - On lbist_resp fire, go to IDLE.
- Timing:
  - Minimum latency from start fire to lbist_resp_val = 2*NUM_SEEDS cycles (1 SEED + 1 WAIT cycle per seed).
  - idx width is $clog2(NUM_SEEDS), minimum 1 bit; idx never wraps inside a run.
- lbist_req_val while busy is not accepted (rdy=0); it must be held by the requester.
- NUM_SEEDS=1 is legal: single pass through SEED/WAIT.

Decomposition:
- lbist_pkg holds:
  - state enum {IDLE, SEED, WAIT, DONE}, 2 bits;
  - a helper function to slice seed[i] and exp[i] from the packed parameters.
- No sub-module: a single FSM plus datapath registers, about 150-200 lines of RTL.

Test Plan:
Configuration for all scenarios: NUM_SEEDS=2, seeds {0xDEADBEEF, 0x12345678}, expected signatures {0xAAAA0001, 0xBBBB0002}.
1. All pass: start; LFSR/MISR always ready; MISR returns 0xAAAA0001 then 0xBBBB0002 -> lfsr msgs 0xDEADBEEF, 0x12345678 in order; misr_req_msg=32 each time; lbist_resp_msg=2'b11 exactly 4 cycles after start fire.
2. Mismatch: same stimulus but second signature 0xBBBB0003 -> lbist_resp_msg=2'b01.
3. Backpressure: lfsr_resp_rdy=0 for 3 cycles in first SEED, misr_req_rdy=1 -> misr_req fires once then val drops; lfsr_resp_val stays 1 with msg 0xDEADBEEF stable; WAIT entered only after the LFSR fire.
4. Result hold: lbist_resp_rdy=0 for 5 cycles in DONE -> val/msg stable; lbist_req_rdy=0 while a new lbist_req_val is asserted; back to IDLE after the fire.
5. Spurious signature: misr_resp_val=1 with 0xAAAA0001 during SEED -> misr_resp_rdy=0, result unchanged, signature consumed only in WAIT.
6. Reset mid-run: reset=0 during WAIT of seed 1 -> all vals 0 immediately (async); after release lbist_req_rdy=1, and a fresh run produces the correct result.
